// File: rtl/trng_health_buffer_if.sv
// Entropy bit stream in, packed word stream out (valid/ready) for trng_health_buffer.
interface trng_health_buffer_if;
  logic        bit_in;
  logic        bit_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport master (output bit_in, bit_valid, word_ready, input word_out, word_valid);
  modport slave  (input bit_in, bit_valid, word_ready, output word_out, word_valid);
endinterface

// File: rtl/trng_health_buffer.sv
// TRNG health stage: repetition-count and adaptive-proportion tests on the debiased
// stream; passing bits are packed MSB-first into 32-bit words and queued in a FIFO.
//
// state   | meaning
// STARTUP | tests running, waiting for one clean APT window, no packing
// RUN     | tests running, passing bits packed and pushed to the FIFO
// ALARM   | health failure latched; datapath held cleared until alarm_clr
module trng_health_buffer #(
  parameter int RCT_CUTOFF = 16,
  parameter int APT_WINDOW = 512,
  parameter int APT_CUTOFF = 410,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  trng_health_buffer_if.slave         bus,
  output logic                        alarm,
  input  logic                        alarm_clr,
  output logic                        startup_done,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int WW = $clog2(APT_WINDOW);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    RCT_LIM  = 8'(RCT_CUTOFF);
  localparam logic [WW-1:0] APT_LIM  = WW'(APT_CUTOFF);
  localparam logic [WW-1:0] WIN_LAST = WW'(APT_WINDOW - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_STARTUP, S_RUN, S_ALARM} state_t;
  state_t state, state_nxt;

  logic [7:0]    rct_cnt;
  logic          prev_bit;
  logic [WW-1:0] apt_cnt;
  logic [WW-1:0] win_cnt;
  logic          apt_ref;
  logic [30:0]   pack;
  logic [4:0]    bit_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   fifo_cnt;

  logic test_en, rct_fail, apt_fail, fail, word_done;
  logic full, not_empty, pop, push, drop, flush;

  // rct_cnt == 0 / win_cnt == 0 mark "first bit after restart" / "first bit of window"
  always_comb begin
    test_en   = en & bus.bit_valid & (state != S_ALARM);
    rct_fail  = test_en & (rct_cnt != '0) & (bus.bit_in == prev_bit) &
                ((rct_cnt + 8'd1) == RCT_LIM);
    apt_fail  = test_en & (win_cnt != '0) & (bus.bit_in == apt_ref) &
                ((apt_cnt + WW'(1)) == APT_LIM);
    fail      = rct_fail | apt_fail;
    word_done = test_en & ~fail & (state == S_RUN) & (bit_cnt == 5'd31);
    not_empty = fifo_cnt != '0;
    full      = fifo_cnt == FULL_LVL;
    pop       = not_empty & bus.word_ready;
    push      = word_done & (~full | pop);
    drop      = word_done & full & ~pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_STARTUP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    flush     = fail;
    case (state)
      S_STARTUP: begin
        if (fail)                                 state_nxt = S_ALARM;
        else if (test_en && (win_cnt == WIN_LAST)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (fail) state_nxt = S_ALARM;
      end
      S_ALARM: begin
        flush = 1'b1;
        if (alarm_clr) state_nxt = S_STARTUP;
      end
      default: state_nxt = S_STARTUP;
    endcase
    alarm        = (state == S_ALARM);
    startup_done = (state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rct_cnt  <= '0;
      prev_bit <= 1'b0;
      apt_cnt  <= '0;
      win_cnt  <= '0;
      apt_ref  <= 1'b0;
      pack     <= '0;
      bit_cnt  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rct_cnt  <= '0;
        prev_bit <= 1'b0;
        apt_cnt  <= '0;
        win_cnt  <= '0;
        apt_ref  <= 1'b0;
        pack     <= '0;
        bit_cnt  <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (test_en) begin
          prev_bit <= bus.bit_in;
          rct_cnt  <= ((rct_cnt != '0) && (bus.bit_in == prev_bit)) ? rct_cnt + 8'd1 : 8'd1;
          if (win_cnt == '0) begin
            apt_ref <= bus.bit_in;
            apt_cnt <= WW'(1);
          end else if (bus.bit_in == apt_ref) begin
            apt_cnt <= apt_cnt + WW'(1);
          end
          win_cnt <= win_cnt + WW'(1);
          if (state == S_RUN) begin
            pack    <= {pack[29:0], bus.bit_in};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (drop)           overflow <= 1'b1;
      else if (alarm_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pack, bus.bit_in};
  end

  assign bus.word_valid = not_empty;
  assign bus.word_out   = not_empty ? mem[rd_ptr] : 32'h0;
  assign fifo_level     = fifo_cnt;
endmodule

// File: tb/tb_trng_health_buffer.sv
// Directed bench for trng_health_buffer with default parameters.
module tb_trng_health_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       alarm_clr = 1'b0;
  logic       alarm, startup_done, overflow;
  logic [2:0] fifo_level;
  int         n_cmp = 0;
  int         n_err = 0;

  trng_health_buffer_if bus ();

  trng_health_buffer dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .alarm(alarm), .alarm_clr(alarm_clr),
    .startup_done(startup_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pat;
    logic        rdy_last;
    logic [31:0] exp_head;
    logic [2:0]  exp_level;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] drain_exp [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    en            = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    step();
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_alt(input int n, input logic first);
    for (int i = 0; i < n; i++) send_bit(first ^ i[0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_out"}, bus.word_out, 32'h0);
    check({tag, "_word_valid"}, 32'(bus.word_valid), 32'h0);
    check({tag, "_alarm"}, 32'(alarm), 32'h0);
    check({tag, "_startup_done"}, 32'(startup_done), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_fifo_level"}, 32'(fifo_level), 32'h0);
  endtask

  task automatic clear_alarm();
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 3'd1, 1'b0};
    vecs[1] = '{32'h3C3C3C3C, 1'b0, 32'hA5A5A5A5, 3'd2, 1'b0};
    vecs[2] = '{32'h0F0F0F0F, 1'b0, 32'hA5A5A5A5, 3'd3, 1'b0};
    vecs[3] = '{32'h6DB6DB6D, 1'b0, 32'hA5A5A5A5, 3'd4, 1'b0};
    vecs[4] = '{32'h12481248, 1'b0, 32'hA5A5A5A5, 3'd4, 1'b1};
    vecs[5] = '{32'hDEADBEEF, 1'b1, 32'h3C3C3C3C, 3'd4, 1'b1};
    drain_exp[0] = 32'h3C3C3C3C;
    drain_exp[1] = 32'h0F0F0F0F;
    drain_exp[2] = 32'h6DB6DB6D;
    drain_exp[3] = 32'hDEADBEEF;

    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // startup on alternating 1,0,...
    send_alt(511, 1'b1);
    check("startup_511", 32'(startup_done), 32'h0);
    send_bit(1'b0);
    check("startup_512", 32'(startup_done), 32'h1);

    // first word, with en low for 3 cycles mid-word
    send_alt(16, 1'b1);
    en = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    repeat (3) step();
    bus.bit_valid = 1'b0;
    send_alt(15, 1'b1);
    check("word1_valid_bit31", 32'(bus.word_valid), 32'h0);
    send_bit(1'b0);
    check("word1_valid", 32'(bus.word_valid), 32'h1);
    check("word1_out", bus.word_out, 32'hAAAAAAAA);
    check("word1_level", 32'(fifo_level), 32'h1);
    check("word1_alarm", 32'(alarm), 32'h0);
    bus.word_ready = 1'b1;
    step();
    check("pop1_valid", 32'(bus.word_valid), 32'h0);
    check("pop1_out", bus.word_out, 32'h0);
    step();
    check("pop_empty_level", 32'(fifo_level), 32'h0);
    bus.word_ready = 1'b0;

    // FIFO fill / overflow / simultaneous push+pop
    for (int v = 0; v < 6; v++) begin
      for (int i = 31; i >= 0; i--) begin
        if (i == 0) bus.word_ready = vecs[v].rdy_last;
        send_bit(vecs[v].pat[i]);
      end
      bus.word_ready = 1'b0;
      check($sformatf("vec%0d_level", v), 32'(fifo_level), 32'(vecs[v].exp_level));
      check($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
      check($sformatf("vec%0d_head", v), bus.word_out, vecs[v].exp_head);
    end
    bus.word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), bus.word_out, drain_exp[k]);
      step();
    end
    bus.word_ready = 1'b0;
    check("drain_valid", 32'(bus.word_valid), 32'h0);
    check("drain_ovf", 32'(overflow), 32'h1);

    // RCT: 15 ones safe, 16th consecutive zero fails on a word-completing bit
    send_word(32'hA5A5A5A5);
    check("rct_pre_level", 32'(fifo_level), 32'h1);
    send_bit(1'b0);
    repeat (15) send_bit(1'b1);
    check("rct_15_ones", 32'(alarm), 32'h0);
    repeat (15) send_bit(1'b0);
    check("rct_15_zeros", 32'(alarm), 32'h0);
    check("rct_15_level", 32'(fifo_level), 32'h1);
    send_bit(1'b0);
    check("rct_alarm", 32'(alarm), 32'h1);
    check("rct_valid", 32'(bus.word_valid), 32'h0);
    check("rct_level", 32'(fifo_level), 32'h0);
    check("rct_out", bus.word_out, 32'h0);
    check("rct_startup_done", 32'(startup_done), 32'h0);
    send_alt(4, 1'b1);
    check("alarm_hold", 32'(alarm), 32'h1);
    check("alarm_hold_level", 32'(fifo_level), 32'h0);
    check("alarm_ovf_sticky", 32'(overflow), 32'h1);
    clear_alarm();
    check("clr_alarm", 32'(alarm), 32'h0);
    check("clr_ovf", 32'(overflow), 32'h0);
    check("clr_startup_done", 32'(startup_done), 32'h0);

    // APT: startup window with 409 ones passes, next window fails on 410th one
    bus.word_ready = 1'b1;
    for (int u = 0; u < 103; u++) begin
      repeat ((u < 100) ? 4 : 3) send_bit(1'b1);
      if (u == 102) check("apt_w1_511", 32'(startup_done), 32'h0);
      send_bit(1'b0);
    end
    check("apt_w1_startup", 32'(startup_done), 32'h1);
    check("apt_w1_alarm", 32'(alarm), 32'h0);
    for (int u = 0; u < 102; u++) begin
      repeat (4) send_bit(1'b1);
      send_bit(1'b0);
    end
    send_bit(1'b1);
    check("apt_409", 32'(alarm), 32'h0);
    send_bit(1'b1);
    check("apt_410", 32'(alarm), 32'h1);
    check("apt_valid", 32'(bus.word_valid), 32'h0);
    bus.word_ready = 1'b0;
    clear_alarm();

    // asynchronous reset mid-word
    send_alt(512, 1'b1);
    check("rst_pre_startup", 32'(startup_done), 32'h1);
    send_alt(32, 1'b1);
    send_alt(17, 1'b1);
    check("rst_pre_level", 32'(fifo_level), 32'h1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    step();
    rst = 1'b1;
    send_alt(512, 1'b0);
    check("rst_startup", 32'(startup_done), 32'h1);
    for (int i = 31; i >= 1; i--) send_bit(1'(32'h5A5A5A5A >> i));
    check("rst_word_valid_31", 32'(bus.word_valid), 32'h0);
    send_bit(1'b0);
    check("rst_word_out", bus.word_out, 32'h5A5A5A5A);
    check("rst_word_level", 32'(fifo_level), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
